// File: rtl/router_reg_if.sv
// Bus between the router FSM/source side and the router_reg datapath stage.
// With ROUTER_REG_ERR_COUNT_EN defined the bus also carries the saturating err_cnt.
interface router_reg_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_addr;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_packet_valid;
  logic                  err;
`ifdef ROUTER_REG_ERR_COUNT_EN
  logic [7:0]            err_cnt;
`endif

  // Strobes are level signals sampled on every rising clk edge; no valid/ready
  // handshake exists here, the FSM strobes fully qualify each cycle's action.
  modport master (
    output pkt_valid, data_in, fifo_full, detect_addr, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
`ifdef ROUTER_REG_ERR_COUNT_EN
    input  err_cnt,
`endif
    input  dout, parity_done, low_packet_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_addr, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
`ifdef ROUTER_REG_ERR_COUNT_EN
    output err_cnt,
`endif
    output dout, parity_done, low_packet_valid, err
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: header/hold capture, FIFO write byte, running parity.
// Optional ROUTER_REG_ERR_COUNT_EN adds a saturating 8-bit count of err rising edges.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  router_reg_if.slave bus
);
  logic [DATA_WIDTH-1:0] r_header_byte;
  logic [DATA_WIDTH-1:0] r_hold_byte;
  logic [DATA_WIDTH-1:0] r_int_parity;
  logic [DATA_WIDTH-1:0] r_pkt_parity;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_parity_done;
  logic                  r_low_packet_valid;
  logic                  r_err;
  logic                  w_err_next;
  logic                  w_hdr_load;

  assign w_hdr_load = bus.detect_addr && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_header_byte <= '0;
      r_hold_byte   <= '0;
      r_dout        <= '0;
    end else begin
      if (w_hdr_load) r_header_byte <= bus.data_in;
      if (bus.lfd_state)                        r_dout      <= r_header_byte;
      else if (bus.ld_state && !bus.fifo_full)  r_dout      <= bus.data_in;
      else if (bus.ld_state && bus.fifo_full)   r_hold_byte <= bus.data_in;
      else if (bus.laf_state)                   r_dout      <= r_hold_byte;
    end
  end

  // The parity byte arrives with pkt_valid low, so it is never folded in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_parity <= '0;
      r_pkt_parity <= '0;
    end else begin
      if (bus.detect_addr)
        r_int_parity <= '0;
      else if (bus.lfd_state)
        r_int_parity <= r_int_parity ^ r_header_byte;
      else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
        r_int_parity <= r_int_parity ^ bus.data_in;

      if (bus.detect_addr)
        r_pkt_parity <= '0;
      else if (bus.ld_state && !bus.pkt_valid)
        r_pkt_parity <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_done      <= 1'b0;
      r_low_packet_valid <= 1'b0;
    end else begin
      if (bus.detect_addr)
        r_parity_done <= 1'b0;
      else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
               (bus.laf_state && r_low_packet_valid && !r_parity_done))
        r_parity_done <= 1'b1;

      if (bus.rst_int_reg)
        r_low_packet_valid <= 1'b0;
      else if (bus.ld_state && !bus.pkt_valid)
        r_low_packet_valid <= 1'b1;
    end
  end

  always_comb begin
    w_err_next = r_err;
    if (bus.detect_addr)
      w_err_next = 1'b0;
    else if (r_parity_done && bus.rst_int_reg)
      w_err_next = (r_int_parity != r_pkt_parity);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_err_next;
  end

`ifdef ROUTER_REG_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  // Counted on the same edge that err goes 0->1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err_cnt <= 8'h00;
    else if (w_err_next && !r_err && (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  assign bus.dout             = r_dout;
  assign bus.parity_done      = r_parity_done;
  assign bus.low_packet_valid = r_low_packet_valid;
  assign bus.err              = r_err;
endmodule

// File: tb/tb_router_reg.sv
// Directed self-checking bench for router_reg; err_cnt scenario only with ROUTER_REG_ERR_COUNT_EN.
module tb_router_reg;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  router_reg_if #(.DATA_WIDTH(8)) bus ();

  router_reg #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one cycle of strobes/data, then sample point is #1 after the edge
  task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fst, input logic rir, input logic pv,
                       input logic [7:0] din, input logic ff);
    bus.detect_addr = da;
    bus.lfd_state   = lfd;
    bus.ld_state    = ld;
    bus.laf_state   = laf;
    bus.full_state  = fst;
    bus.rst_int_reg = rir;
    bus.pkt_valid   = pv;
    bus.data_in     = din;
    bus.fifo_full   = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic send_bad_packet();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h05, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h11, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h11, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
  endtask

  task automatic test_reset();
    n_checks++; if (bus.dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", bus.dout); else n_pass++;
    n_checks++; if ({bus.parity_done, bus.low_packet_valid, bus.err} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {bus.parity_done, bus.low_packet_valid, bus.err}); else n_pass++;
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 1, 8'h09, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h33, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h33, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h44, 0);
    n_checks++; if ({bus.dout, bus.parity_done, bus.low_packet_valid} !== {8'h44, 2'b11})
      $display("FAIL pre_reset_state got=%h/%b%b exp=44/11", bus.dout, bus.parity_done, bus.low_packet_valid); else n_pass++;
    idle();
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.dout !== 8'h00) $display("FAIL async_reset_dout got=%h exp=00", bus.dout); else n_pass++;
    n_checks++; if ({bus.parity_done, bus.low_packet_valid, bus.err} !== 3'b000)
      $display("FAIL async_reset_flags got=%b exp=000", {bus.parity_done, bus.low_packet_valid, bus.err}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    n_checks++; if (bus.dout !== 8'h00) $display("FAIL reset_header_cleared got=%h exp=00", bus.dout); else n_pass++;
  endtask

  task automatic test_good_packet();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h05, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h11, 0);
    n_checks++; if (bus.dout !== 8'h05) $display("FAIL good_dout_hdr got=%h exp=05", bus.dout); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 1, 8'h11, 0);
    n_checks++; if (bus.dout !== 8'h11) $display("FAIL good_dout_p0 got=%h exp=11", bus.dout); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 1, 8'h22, 0);
    n_checks++; if (bus.dout !== 8'h22) $display("FAIL good_dout_p1 got=%h exp=22", bus.dout); else n_pass++;
    n_checks++; if (bus.parity_done !== 1'b0) $display("FAIL good_pd_early got=%b exp=0", bus.parity_done); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 8'h36, 0);
    n_checks++; if (bus.parity_done !== 1'b1) $display("FAIL good_pd got=%b exp=1", bus.parity_done); else n_pass++;
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    n_checks++; if (bus.err !== 1'b0) $display("FAIL good_err got=%b exp=0", bus.err); else n_pass++;
    n_checks++; if (bus.low_packet_valid !== 1'b0) $display("FAIL good_lpv_clr got=%b exp=0", bus.low_packet_valid); else n_pass++;
  endtask

  task automatic test_bad_parity();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h05, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h11, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h11, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h22, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    n_checks++; if (bus.err !== 1'b1) $display("FAIL bad_err_set got=%b exp=1", bus.err); else n_pass++;
    idle();
    n_checks++; if (bus.err !== 1'b1) $display("FAIL bad_err_hold got=%b exp=1", bus.err); else n_pass++;
    drive(1, 0, 0, 0, 0, 0, 1, 8'h06, 0);
    n_checks++; if ({bus.err, bus.parity_done} !== 2'b00)
      $display("FAIL bad_err_clr got=%b exp=00", {bus.err, bus.parity_done}); else n_pass++;
  endtask

  task automatic test_fifo_full();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h05, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'hAA, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'hAA, 1);
    n_checks++; if (bus.dout !== 8'h05) $display("FAIL full_dout_hold got=%h exp=05", bus.dout); else n_pass++;
    drive(0, 0, 0, 0, 1, 0, 1, 8'hBB, 1);
    n_checks++; if (bus.dout !== 8'h05) $display("FAIL full_state_hold got=%h exp=05", bus.dout); else n_pass++;
    drive(0, 0, 0, 1, 0, 0, 1, 8'hBB, 0);
    n_checks++; if (bus.dout !== 8'hAA) $display("FAIL laf_dout got=%h exp=aa", bus.dout); else n_pass++;
    // parity so far 05^AA = AF
    drive(0, 0, 1, 0, 0, 0, 0, 8'hAF, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    n_checks++; if ({bus.parity_done, bus.err} !== 2'b10)
      $display("FAIL full_parity got=%b exp=10", {bus.parity_done, bus.err}); else n_pass++;
  endtask

  task automatic test_low_packet();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h05, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h05, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h05, 1);
    n_checks++; if ({bus.low_packet_valid, bus.parity_done} !== 2'b10)
      $display("FAIL low_lpv got=%b exp=10", {bus.low_packet_valid, bus.parity_done}); else n_pass++;
    drive(0, 0, 0, 0, 1, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    n_checks++; if (bus.parity_done !== 1'b1) $display("FAIL low_pd_laf got=%b exp=1", bus.parity_done); else n_pass++;
    n_checks++; if (bus.dout !== 8'h05) $display("FAIL low_dout_laf got=%h exp=05", bus.dout); else n_pass++;
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    n_checks++; if ({bus.low_packet_valid, bus.err} !== 2'b00)
      $display("FAIL low_lpv_clr got=%b exp=00", {bus.low_packet_valid, bus.err}); else n_pass++;
    // clear beats set when both arrive together
    drive(0, 0, 1, 0, 0, 1, 0, 8'h00, 0);
    n_checks++; if (bus.low_packet_valid !== 1'b0) $display("FAIL lpv_clr_wins got=%b exp=0", bus.low_packet_valid); else n_pass++;
  endtask

  task automatic test_addr3_and_zero_payload();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h0A, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 8'hF7, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    n_checks++; if (bus.dout !== 8'h0A) $display("FAIL addr3_ignored got=%h exp=0a", bus.dout); else n_pass++;
    drive(0, 0, 1, 0, 0, 0, 0, 8'h0A, 0);
    n_checks++; if ({bus.dout, bus.parity_done} !== {8'h0A, 1'b1})
      $display("FAIL zero_payload got=%h/%b exp=0a/1", bus.dout, bus.parity_done); else n_pass++;
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    n_checks++; if (bus.err !== 1'b0) $display("FAIL zero_payload_err got=%b exp=0", bus.err); else n_pass++;
  endtask

`ifdef ROUTER_REG_ERR_COUNT_EN
  task automatic test_err_count();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (bus.err_cnt !== 8'h00) $display("FAIL errcnt_reset got=%h exp=00", bus.err_cnt); else n_pass++;
    for (int i = 0; i < 3; i++) send_bad_packet();
    n_checks++; if (bus.err_cnt !== 8'h03) $display("FAIL errcnt_3 got=%h exp=03", bus.err_cnt); else n_pass++;
    for (int i = 0; i < 257; i++) send_bad_packet();
    n_checks++; if (bus.err_cnt !== 8'hFF) $display("FAIL errcnt_sat got=%h exp=ff", bus.err_cnt); else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.detect_addr = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state  = 0; bus.rst_int_reg = 0; bus.pkt_valid = 0; bus.data_in = 8'h00;
    bus.fifo_full   = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_fifo_full();
    test_low_packet();
    test_addr3_and_zero_payload();
`ifdef ROUTER_REG_ERR_COUNT_EN
    test_err_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router, directly downstream of the router FSM.
- Consumes the FSM state strobes and the serial byte stream, and produces the byte written into the selected output FIFO.
- Holds the header byte and any byte arriving while the FIFO is full, and computes running XOR parity.
- Flags parity errors and tells the FSM when parity is done and when a packet ended short.

Parameters:
- DATA_WIDTH, 8, byte width of data_in and dout. Header address field is always bits [1:0].

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- pkt_valid  input  1  source byte valid; deasserts with the parity byte.
- data_in  input  DATA_WIDTH  source byte: header, payload, then parity.
- fifo_full  input  1  selected output FIFO full.
- detect_addr  input  1  FSM in decode_address.
- lfd_state  input  1  FSM in load_first_data.
- ld_state  input  1  FSM in load_data.
- laf_state  input  1  FSM in load_after_full.
- full_state  input  1  FSM in fifo_full_state.
- rst_int_reg  input  1  FSM in check_parity_error.
- dout  output  DATA_WIDTH  byte to the FIFO write port.
- parity_done  output  1  parity byte has been captured.
- low_packet_valid  output  1  pkt_valid fell while in load_data.
- err  output  1  packet parity mismatch.

Behaviour:
- Reset: dout, parity_done, low_packet_valid and err are 0. The internal regs header_byte, hold_byte, int_parity and pkt_parity are also 0.
- Reset is asynchronous. Asserting it mid-packet clears everything immediately. No state survives.
- Header capture: when detect_addr && pkt_valid && data_in[1:0]!=2'b11, header_byte<=data_in. Address 3 is ignored.
- dout has one-cycle registered latency. Priority, highest first:
  - lfd_state: dout<=header_byte.
  - ld_state && !fifo_full: dout<=data_in.
  - ld_state && fifo_full: hold_byte<=data_in; dout holds.
  - laf_state: dout<=hold_byte.
  - otherwise dout holds.
- int_parity:
  - detect_addr: cleared to 0.
  - lfd_state: int_parity ^= header_byte.
  - ld_state && pkt_valid && !full_state: int_parity ^= data_in.
  - The parity byte itself is never folded in.
- pkt_parity: captured from data_in when ld_state && !pkt_valid. Cleared on detect_addr.
- parity_done:
  - Set by (ld_state && !fifo_full && !pkt_valid).
  - Also set by (laf_state && low_packet_valid && !parity_done).
  - Cleared on detect_addr; otherwise holds.
- low_packet_valid: set by ld_state && !pkt_valid. Cleared by rst_int_reg. Clear wins if both are asserted.
- err:
  - Evaluated on the cycle parity_done is 1 and rst_int_reg is 1: err<=(int_parity!=pkt_parity).
  - Cleared on detect_addr; otherwise holds.
- Simultaneous detect_addr with any other strobe: clear actions apply.
- Header capture still occurs in that same cycle.
- Zero-payload packet (pkt_valid drops right after the header): parity = header byte. parity_done sets on the first ld_state cycle.
- One-hot state strobes are assumed. Multiple strobes resolve by the priority order above, with no X on outputs.

Optional Feature:
- Macro ROUTER_REG_ERR_COUNT_EN.
- With the macro defined:
  - Extra output err_cnt, 8 bits, reset 0.
  - Increments by 1 on every cycle err rises 0->1.
  - Saturates at 8'hFF.
  - Cleared only by rst.
- Without it, no err_cnt port or logic exists. All other behaviour is identical.

Test Plan:
- rst=1 mid-packet, then released -> dout=0, parity_done=0, low_packet_valid=0, err=0 at once, without waiting for a clock edge.
- Header 8'h05 (addr 1), payload 8'h11, 8'h22, parity 8'h36, fifo_full=0 -> dout sequence 05,11,22; parity_done=1 after the parity cycle; err=0.
- Same packet with parity 8'h00 -> err=1 in check_parity_error; cleared on the next detect_addr.
- fifo_full=1 while payload 8'hAA arrives in load_data, then laf_state -> dout=8'hAA one cycle after laf_state is asserted.
- pkt_valid low in load_data with fifo_full=1, then laf_state -> low_packet_valid=1, parity_done sets in laf, low_packet_valid clears on rst_int_reg.
- ROUTER_REG_ERR_COUNT_EN defined, 3 bad-parity packets sent -> err_cnt=3. 260 bad packets -> err_cnt=8'hFF.
